// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC register and sequences imem fetch, decode hold and PC update
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             leave IDLE and begin fetching (sampled in IDLE only)
//   imem_req/addr     one-cycle fetch request pulse, address = pc
//   imem_rdy/data     imem response strobe and instruction word
//   inst/inst_valid   held instruction to decode
//   inst_ready        decode accepts inst
//   pc                current PC, to pc_control.pc_in
//   pc_next_in        next PC from pc_control.pc_out, sampled on accept only
//   halted            sequencer stopped until reset
//   fetch_err         sticky imem timeout flag
//   misalign_err      sticky odd-next-PC flag
//   retired_cnt       accepted non-halt instructions, wrapping
module pc_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] pc,
    input  logic [15:0] pc_next_in,
    output logic        halted,
    output logic        fetch_err,
    output logic        misalign_err,
    output logic [15:0] retired_cnt
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, VALID, HALT} state_t;
    state_t state, state_nxt;
    logic [15:0] wait_cnt;
    logic accept, is_halt, timeout;
    assign imem_addr = pc;
    assign accept = (state == VALID) && inst_ready;
    assign is_halt = inst[15:12] == HALT_OP;
    // wait_cnt holds the number of earlier empty WAIT cycles, so the TIMEOUT-th empty cycle trips;
    // a response arriving in that same cycle takes priority
    assign timeout = (state == WAIT) && !imem_rdy && (wait_cnt == 16'(TIMEOUT - 1));
    always_comb begin
        state_nxt = state;
        imem_req = 1'b0;
        inst_valid = 1'b0;
        halted = 1'b0;
        case (state)
            IDLE:  state_nxt = start ? FETCH : IDLE;
            FETCH: begin
                imem_req = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  state_nxt = imem_rdy ? VALID : (timeout ? HALT : WAIT);
            VALID: begin
                inst_valid = 1'b1;
                state_nxt = !inst_ready ? VALID : ((is_halt || pc_next_in[0]) ? HALT : FETCH);
            end
            HALT:  halted = 1'b1;
            default: state_nxt = HALT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= RESET_PC;
            inst <= '0;
            wait_cnt <= '0;
            fetch_err <= 1'b0;
            misalign_err <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH)
                wait_cnt <= '0;
            else if (state == WAIT && !imem_rdy)
                wait_cnt <= wait_cnt + 16'd1;
            if (state == WAIT && imem_rdy)
                inst <= imem_data;
            if (timeout)
                fetch_err <= 1'b1;
            // a halt opcode retires nothing and leaves pc alone; an odd target is refused
            if (accept && !is_halt) begin
                if (pc_next_in[0]) begin
                    misalign_err <= 1'b1;
                end else begin
                    pc <= pc_next_in;
                    retired_cnt <= retired_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: scoreboard bench for pc_fetch_sequencer with directed and random fetch sessions
module tb_pc_fetch_sequencer;
    localparam int TIMEOUT = 16;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, imem_rdy = 1'b0, inst_ready = 1'b0;
    logic [15:0] imem_data = '0, pc_next_in = '0;
    logic        imem_req, inst_valid, halted, fetch_err, misalign_err;
    logic [15:0] imem_addr, inst, pc, retired_cnt;
    int checks = 0, failures = 0;
    logic [15:0] exp_addr[$];
    logic [15:0] exp_inst[$];
    logic [15:0] exp_pc = '0, exp_ret = '0;
    logic        exp_halt = 1'b0, exp_ferr = 1'b0, exp_merr = 1'b0;

    pc_fetch_sequencer #(.RESET_PC(16'h0000), .HALT_OP(4'hF), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .pc(pc), .pc_next_in(pc_next_in),
        .halted(halted), .fetch_err(fetch_err), .misalign_err(misalign_err), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // monitor: every request and every accept must match the next expected item
    always @(negedge clk) begin
        if (rst_n && imem_req) begin
            if (exp_addr.size() == 0) fail("unexpected_req", $sformatf("imem_req at %h with none expected", imem_addr));
            else chk("req_addr", imem_addr, exp_addr.pop_front());
        end
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_inst.size() == 0) fail("unexpected_inst", $sformatf("inst %h offered with none expected", inst));
            else chk("accept_inst", inst, exp_inst.pop_front());
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_retired"}, retired_cnt, exp_ret);
        chk({tag, "_halted"}, 16'(halted), 16'(exp_halt));
        chk({tag, "_fetch_err"}, 16'(fetch_err), 16'(exp_ferr));
        chk({tag, "_misalign_err"}, 16'(misalign_err), 16'(exp_merr));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        start = 1'b0;
        imem_rdy = 1'b0;
        inst_ready = 1'b0;
        #1;
        exp_addr.delete();
        exp_inst.delete();
        exp_pc = 16'h0000;
        exp_ret = '0;
        exp_halt = 1'b0;
        exp_ferr = 1'b0;
        exp_merr = 1'b0;
        check_state("reset");
        chk("reset_inst", inst, 16'h0000);
        chk("reset_inst_valid", 16'(inst_valid), 16'd0);
        chk("reset_imem_req", 16'(imem_req), 16'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        exp_addr.push_back(exp_pc);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    // one fetch: respond after `delay` empty WAIT cycles, hold decode for `hold` cycles, accept with nxt
    task automatic do_fetch(input int delay, input logic [15:0] data, input int hold, input logic [15:0] nxt);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!imem_req) begin
            fail("req_wait", "no imem_req within 20 cycles");
            return;
        end
        imem_rdy = 1'($urandom_range(0, 1));
        imem_data = 16'($urandom);
        @(posedge clk);
        #2;
        imem_rdy = 1'b0;
        if (delay >= TIMEOUT) begin
            repeat (TIMEOUT) begin
                @(posedge clk);
                #2;
            end
            exp_halt = 1'b1;
            exp_ferr = 1'b1;
            check_state("timeout");
            return;
        end
        repeat (delay) begin
            @(posedge clk);
            #2;
        end
        chk("wait_no_valid", 16'(inst_valid), 16'd0);
        imem_rdy = 1'b1;
        imem_data = data;
        exp_inst.push_back(data);
        @(posedge clk);
        #2;
        imem_rdy = 1'b0;
        chk("valid_after_rdy", 16'(inst_valid), 16'd1);
        chk("no_err_on_data", 16'(fetch_err), 16'd0);
        repeat (hold) begin
            chk("hold_inst", inst, data);
            chk("hold_valid", 16'(inst_valid), 16'd1);
            chk("hold_no_req", 16'(imem_req), 16'd0);
            imem_rdy = 1'($urandom_range(0, 1));
            imem_data = 16'($urandom);
            @(posedge clk);
            #2;
        end
        imem_rdy = 1'b0;
        inst_ready = 1'b1;
        pc_next_in = nxt;
        if (data[15:12] == 4'hF) begin
            exp_halt = 1'b1;
        end else if (nxt[0]) begin
            exp_halt = 1'b1;
            exp_merr = 1'b1;
        end else begin
            exp_pc = nxt;
            exp_ret++;
            exp_addr.push_back(nxt);
        end
        @(posedge clk);
        #2;
        inst_ready = 1'b0;
        pc_next_in = 16'($urandom);
        chk("req_after_accept", 16'(imem_req), 16'(!exp_halt));
        check_state("accept");
    endtask

    task automatic check_halt_idle();
        start = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        chk("halt_inst_valid", 16'(inst_valid), 16'd0);
        chk("halt_imem_req", 16'(imem_req), 16'd0);
        check_state("halted");
    endtask

    initial begin
        logic [15:0] d;
        int kind;
        do_reset();
        do_start();
        do_fetch(2, 16'h1234, 0, 16'h0002);
        do_fetch(1, 16'h2345, 0, 16'h0010);
        do_fetch(0, 16'h3456, 5, 16'h0020);
        chk("retired_after_three", retired_cnt, 16'd3);
        do_fetch(0, 16'hF000, 2, 16'h0100);
        check_halt_idle();

        do_reset();
        do_start();
        do_fetch(TIMEOUT, 16'h0000, 0, 16'h0000);
        check_halt_idle();

        do_reset();
        do_start();
        do_fetch(TIMEOUT - 1, 16'h0ABC, 0, 16'h0004);
        do_fetch(0, 16'h1111, 1, 16'h0003);
        check_halt_idle();

        do_reset();
        do_start();
        do_fetch(0, 16'h2222, 0, 16'hFFFE);
        do_fetch(0, 16'h3333, 1, 16'h0000);
        @(posedge clk);
        #2;
        do_reset();
        imem_rdy = 1'b1;
        imem_data = 16'hBEEF;
        @(posedge clk);
        #2;
        imem_rdy = 1'b0;
        chk("dropped_resp_inst", inst, 16'h0000);
        chk("dropped_resp_valid", 16'(inst_valid), 16'd0);
        do_start();
        do_fetch(1, 16'h4444, 0, 16'h0008);

        for (int s = 0; s < 8; s++) begin
            do_reset();
            do_start();
            for (int i = 0; i < int'($urandom_range(3, 10)); i++) begin
                d = 16'($urandom);
                if (d[15:12] == 4'hF) d[15:12] = 4'h0;
                do_fetch(int'($urandom_range(0, 5)), d, int'($urandom_range(0, 4)), 16'($urandom) & 16'hFFFE);
            end
            kind = int'($urandom_range(0, 2));
            d = 16'($urandom);
            if (kind == 0) do_fetch(int'($urandom_range(0, 5)), {4'hF, d[11:0]}, int'($urandom_range(0, 3)), 16'($urandom) & 16'hFFFE);
            else if (kind == 1) do_fetch(int'($urandom_range(0, 5)), {4'h1, d[11:0]}, int'($urandom_range(0, 3)), 16'($urandom) | 16'h0001);
            else do_fetch(TIMEOUT + int'($urandom_range(0, 3)), d, 0, 16'h0000);
            check_halt_idle();
        end
        chk("queues_empty", 16'(exp_addr.size() + exp_inst.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
